// File: rtl/up_down_mod_counter_if.sv
// rtl/up_down_mod_counter_if.sv - control and status bundle for the up/down modulo counter
interface up_down_mod_counter_if #(
   parameter int SIZE = 4
);
   logic [SIZE-1:0] PI;
   logic [SIZE-1:0] modVal;
   logic            ld;
   logic            en;
   logic            carryIn;
   logic            up;
   logic            oneShot;
   logic [SIZE-1:0] PO;
   logic            carryOut;
   logic            tc;
   logic            done;

   modport master (
      output PI, modVal, ld, en, carryIn, up, oneShot,
      input  PO, carryOut, tc, done
   );

   modport slave (
      input  PI, modVal, ld, en, carryIn, up, oneShot,
      output PO, carryOut, tc, done
   );
endinterface

// File: rtl/up_down_mod_counter.sv
// rtl/up_down_mod_counter.sv - cascadable up/down counter over 0..modVal with wrap or one-shot stop
module up_down_mod_counter #(
   parameter int SIZE = 4
) (
   input logic                   clk,
   input logic                   rst,
   up_down_mod_counter_if.slave  bus
);
   logic [SIZE-1:0] r_po;
   logic            r_tc;
   logic            r_done;

   logic            w_blocked;
   logic            w_term;
   logic            w_step;
   logic [SIZE-1:0] w_load_val;
   logic [SIZE-1:0] w_up_val;
   logic [SIZE-1:0] w_down_val;
   logic [SIZE-1:0] w_next_po;
   logic            w_next_tc;
   logic            w_next_done;

   // A finished one-shot only blocks stepping while oneShot is still asserted.
   assign w_blocked  = bus.oneShot & r_done;
   assign w_term     = bus.up ? (r_po >= bus.modVal) : (r_po == '0);
   assign w_step     = bus.en & bus.carryIn & ~w_blocked;
   assign w_load_val = (bus.PI > bus.modVal) ? bus.modVal : bus.PI;
   assign w_up_val   = r_po + SIZE'(1);
   // A count left above a freshly lowered modVal re-enters the range at the top.
   assign w_down_val = (r_po > bus.modVal) ? bus.modVal : (r_po - SIZE'(1));

   always_comb begin
      w_next_po   = r_po;
      w_next_tc   = 1'b0;
      w_next_done = r_done;
      if (bus.ld) begin
         w_next_po   = w_load_val;
         w_next_done = 1'b0;
      end else if (w_step) begin
         if (w_term) begin
            w_next_tc = 1'b1;
            if (bus.oneShot) begin
               w_next_done = 1'b1;
            end else begin
               w_next_po = bus.up ? '0 : bus.modVal;
            end
         end else begin
            w_next_po = bus.up ? w_up_val : w_down_val;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_po   <= '0;
         r_tc   <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_po   <= w_next_po;
         r_tc   <= w_next_tc;
         r_done <= w_next_done;
      end
   end

   assign bus.PO       = r_po;
   assign bus.tc       = r_tc;
   assign bus.done     = r_done;
   assign bus.carryOut = w_step & w_term;
endmodule

// File: doc/up_down_mod_counter.md
UP_DOWN_MOD_COUNTER -- requirements
Module: up_down_mod_counter

Interface
REQ-001 The block SHALL have parameter SIZE, default 4, giving the counter width in bits (SIZE >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port PI, input, SIZE bits: parallel load value.
REQ-005 The block SHALL have port modVal, input, SIZE bits: terminal value M; the count range is 0..M inclusive.
REQ-006 The block SHALL have port ld, input, 1 bit: parallel load request.
REQ-007 The block SHALL have port en, input, 1 bit: counter enable.
REQ-008 The block SHALL have port carryIn, input, 1 bit: cascade step request from the lower stage.
REQ-009 The block SHALL have port up, input, 1 bit: 1 = count up, 0 = count down.
REQ-010 The block SHALL have port oneShot, input, 1 bit: 1 = stop at terminal, 0 = wrap.
REQ-011 The block SHALL have port PO, output, SIZE bits: registered count.
REQ-012 The block SHALL have port carryOut, output, 1 bit: combinational cascade carry/borrow to the next stage.
REQ-013 The block SHALL have port tc, output, 1 bit: registered terminal-count pulse.
REQ-014 The block SHALL have port done, output, 1 bit: registered sticky one-shot completion flag.

Function
REQ-015 Update priority SHALL be reset > ld > step > hold.
REQ-016 A "step" SHALL occur on a clock edge when rst=1, ld=0, en=1, carryIn=1, and NOT (oneShot=1 and done=1).
REQ-017 On ld=1, PO SHALL take min(PI, modVal), done SHALL clear, and tc SHALL be 0 the next cycle, regardless of en.
REQ-018 Terminal condition T SHALL be (up=1 and PO >= modVal) or (up=0 and PO == 0).
REQ-019 On an up step with T=0, PO SHALL take PO+1.
REQ-020 On a down step with T=0, PO SHALL take PO-1 when PO <= modVal, and modVal when PO > modVal.
REQ-021 On a step with T=1 and oneShot=0, PO SHALL wrap: to 0 when counting up, to modVal when counting down.
REQ-022 On a step with T=1 and oneShot=1, PO SHALL hold and done SHALL set to 1.
REQ-023 tc SHALL be 1 in the cycle after any step taken with T=1 (wrap or one-shot terminal), and 0 otherwise; it is a one-cycle pulse per terminal step.
REQ-024 done SHALL stay 1 until ld=1 or reset; while done=1 and oneShot=1 no step occurs, and PO and tc hold at their current value and 0 respectively.
REQ-025 If oneShot drops to 0 while done=1, done SHALL stay 1 but steps SHALL resume per REQ-016.
REQ-026 carryOut SHALL be en & carryIn & T & NOT (oneShot & done), evaluated combinationally from current PO, up and modVal.
REQ-027 With modVal=0, every step SHALL be terminal: PO stays 0, tc pulses per step, and carryOut = en & carryIn (subject to REQ-026).
REQ-028 Changing modVal or up SHALL take effect on the next edge, with no extra latency.
REQ-029 All arithmetic SHALL be unsigned, modulo 2^SIZE; no intermediate value outside 0..modVal is ever written to PO except via REQ-017 clamping (never).

Reset
REQ-030 When rst=0 at a rising clk edge, PO SHALL be 0, tc SHALL be 0 and done SHALL be 0 on the next cycle, overriding ld and en.
REQ-031 A reset asserted mid-count or mid-one-shot SHALL take effect on that edge; counting resumes from 0 on the first edge with rst=1.
REQ-032 carryOut SHALL reflect post-reset state combinationally (PO=0) once reset has been applied.

Verification (SIZE=4)
REQ-033 Up wrap: modVal=9, oneShot=0, up=1, en=carryIn=1 for 12 cycles from reset -> PO 1..9,0,1,2; carryOut=1 while PO=9; tc=1 only in the cycle PO returns to 0.
REQ-034 Down one-shot: ld PI=3, modVal=9, up=0, oneShot=1, then step -> PO 2,1,0,0,0; done=1 from the cycle after the step at PO=0; tc pulses once; carryOut=0 after done.
REQ-035 Load clamp and priority: PI=14, modVal=9, ld=1 with en=carryIn=1 -> PO=9, tc=0, done cleared; next up step -> PO=0 with tc=1.
REQ-036 Cascade hold: en=1, carryIn alternating 1/0, up=1, modVal=15 -> PO advances only on carryIn=1 edges; carryOut=1 only when PO=15 and carryIn=1.
REQ-037 Reset mid-operation: counting up at PO=6 with done=1 (oneShot=1), assert rst=0 for one edge with ld=1 -> PO=0, done=0, tc=0; counting resumes at 1.
REQ-038 modVal shrink: PO=8, change modVal to 5, down step -> PO=5; up step from PO=8 -> PO=0 with tc=1.
